// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with interrupt pending/enable logic,
// single-level trap entry/return and a free-running 64-bit cycle counter.
// Reads are combinational from current state; all updates happen on the
// rising clock edge. A trap taken in a cycle suppresses any CSR write and
// any mret in that same cycle.
module csr_unit #(
    parameter int          NUM_IRQ   = 16,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [2:0]         opcode_i,
    input  logic [11:0]        addr_i,
    input  logic [31:0]        rs1_data_i,
    input  logic [31:0]        imm_data_i,
    input  logic               write_enable_i,
    input  logic [31:0]        pc_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               mret_i,
    output logic [31:0]        read_data_o,
    output logic               illegal_o,
    output logic               trap_o,
    output logic [31:0]        trap_pc_o,
    output logic [31:0]        mepc_o
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

    // Interrupt lines occupy bits [16+NUM_IRQ-1:16] of mie and mip.
    localparam logic [31:0] IRQ_MASK = 32'(((64'd1 << NUM_IRQ) - 64'd1) << 16);

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mip_q,      mip_d;
    logic [63:0] mcycle_q,   mcycle_d;
    logic        trap_q,     trap_d;

    logic        op_valid;
    logic        mapped;
    logic [31:0] rdata;
    logic [31:0] operand;
    logic [31:0] wdata;
    logic        wr_en;
    logic [31:0] pending;
    logic        trap_fire;
    logic [4:0]  trap_idx;
    logic        found;
    logic [5:0]  cause_code;
    logic [31:0] ack_mask;
    logic [31:0] irq_ext;
    logic [31:0] mtvec_base;

    // Every opcode with a nonzero low pair is a real CSR operation.
    assign op_valid = |opcode_i[1:0];
    assign illegal_o = op_valid & ~mapped;
    assign read_data_o = rdata;
    assign operand = opcode_i[2] ? imm_data_i : rs1_data_i;

    // Address decode and combinational read mux from pre-edge state.
    always_comb begin
        rdata  = 32'd0;
        mapped = 1'b1;
        case (addr_i)
            ADDR_MSTATUS:  rdata = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            ADDR_MIE:      rdata = mie_q;
            ADDR_MTVEC:    rdata = mtvec_q;
            ADDR_MSCRATCH: rdata = mscratch_q;
            ADDR_MEPC:     rdata = mepc_q;
            ADDR_MCAUSE:   rdata = mcause_q;
            ADDR_MIP:      rdata = mip_q;
            ADDR_MCYCLE:   rdata = mcycle_q[31:0];
            ADDR_MCYCLEH:  rdata = mcycle_q[63:32];
            default:       mapped = 1'b0;
        endcase
    end

    // Read-modify-write data: write, set bits, or clear bits of the old value.
    always_comb begin
        case (opcode_i[1:0])
            2'b10:   wdata = rdata | operand;
            2'b11:   wdata = rdata & ~operand;
            default: wdata = operand;
        endcase
    end

    // Trap detection and lowest-index winner among pending enabled lines.
    always_comb begin
        pending   = mip_q & mie_q;
        trap_fire = mstatus_mie_q & (|pending);
        trap_idx  = 5'd0;
        found     = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!found && pending[16+i]) begin
                found    = 1'b1;
                trap_idx = 5'(i);
            end
        end
        cause_code = 6'd16 + {1'b0, trap_idx};
        ack_mask   = 32'd1 << cause_code;
    end

    // Incoming level requests placed at their mip bit positions.
    always_comb begin
        irq_ext = 32'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            irq_ext[16+i] = irq_i[i];
        end
    end

    assign wr_en = write_enable_i & op_valid & mapped & ~trap_fire;

    // Next-state computation; trap beats mret, mret beats a software write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mip_d          = mip_q;
        mcycle_d       = mcycle_q + 64'd1;
        trap_d         = trap_fire;

        if (trap_fire) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mepc_d         = pc_i;
            mcause_d       = 32'h8000_0000 | {26'd0, cause_code};
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_en && addr_i == ADDR_MSTATUS) begin
            mstatus_mie_d  = wdata[3];
            mstatus_mpie_d = wdata[7];
        end

        if (wr_en) begin
            case (addr_i)
                ADDR_MIE:      mie_d = wdata & IRQ_MASK;
                ADDR_MTVEC:    mtvec_d = {wdata[31:2], (wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
                ADDR_MSCRATCH: mscratch_d = wdata;
                ADDR_MEPC:     mepc_d = wdata;
                ADDR_MCAUSE:   mcause_d = wdata;
                ADDR_MIP:      mip_d = mip_q & wdata;
                ADDR_MCYCLE:   mcycle_d[31:0] = wdata;
                ADDR_MCYCLEH:  mcycle_d[63:32] = wdata;
                default:       ;
            endcase
        end

        // Software may only clear pending bits; a new request always wins.
        if (trap_fire) begin
            mip_d = mip_d & ~ack_mask;
        end
        mip_d = (mip_d | irq_ext) & IRQ_MASK;
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'd0;
            mtvec_q        <= MTVEC_RST;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mip_q          <= 32'd0;
            mcycle_q       <= 64'd0;
            trap_q         <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mip_q          <= mip_d;
            mcycle_q       <= mcycle_d;
            trap_q         <= trap_d;
        end
    end

    // Vectored mode offsets the base by four times the captured cause code.
    assign mtvec_base = {mtvec_q[31:2], 2'b00};
    assign trap_pc_o  = (mtvec_q[1:0] == 2'b01) ? mtvec_base + {mcause_q[29:0], 2'b00} : mtvec_base;
    assign trap_o     = trap_q;
    assign mepc_o     = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed scenarios plus randomized traffic for csr_unit,
// checked every cycle against a behavioural model of the CSR rules.
module tb_csr_unit;

    localparam logic [31:0] TB_MTVEC = 32'h0000_0101;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [2:0]  opcode_i = '0;
    logic [11:0] addr_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] imm_data_i = '0;
    logic        write_enable_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [15:0] irq_i = '0;
    logic        mret_i = 1'b0;
    logic [31:0] read_data_o;
    logic        illegal_o;
    logic        trap_o;
    logic [31:0] trap_pc_o;
    logic [31:0] mepc_o;

    int n_cmp = 0;
    int n_err = 0;

    csr_unit #(.NUM_IRQ(16), .MTVEC_RST(TB_MTVEC)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .opcode_i       (opcode_i),
        .addr_i         (addr_i),
        .rs1_data_i     (rs1_data_i),
        .imm_data_i     (imm_data_i),
        .write_enable_i (write_enable_i),
        .pc_i           (pc_i),
        .irq_i          (irq_i),
        .mret_i         (mret_i),
        .read_data_o    (read_data_o),
        .illegal_o      (illegal_o),
        .trap_o         (trap_o),
        .trap_pc_o      (trap_pc_o),
        .mepc_o         (mepc_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // ---------------- behavioural model ----------------
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
    logic [63:0] m_cycle;
    logic        m_trap_o;

    function automatic bit m_mapped(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                         12'h342, 12'h344, 12'hB00, 12'hB80};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_trap_pc();
        logic [31:0] base;
        base = m_mtvec & 32'hFFFF_FFFC;
        if (m_mtvec[1:0] == 2'b01) return base + m_mcause * 32'd4;
        return base;
    endfunction

    task automatic m_reset();
        m_mstatus  = 32'd0;
        m_mie      = 32'd0;
        m_mtvec    = TB_MTVEC;
        m_mscratch = 32'd0;
        m_mepc     = 32'd0;
        m_mcause   = 32'd0;
        m_mip      = 32'd0;
        m_cycle    = 64'd0;
        m_trap_o   = 1'b0;
    endtask

    task automatic m_step();
        logic [31:0] pend, old, opnd, wd;
        logic [31:0] n_ms, n_mie, n_tv, n_scr, n_epc, n_cause, n_mip;
        logic [63:0] n_cyc;
        bit trap, valid, we;
        int k;
        pend  = m_mip & m_mie;
        trap  = m_mstatus[3] && (pend != 32'd0);
        k = 0;
        for (int i = 31; i >= 16; i--) if (pend[i]) k = i;
        valid = opcode_i inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        old   = m_read(addr_i);
        opnd  = opcode_i[2] ? imm_data_i : rs1_data_i;
        case (opcode_i[1:0])
            2'd1:    wd = opnd;
            2'd2:    wd = old | opnd;
            default: wd = old & ~opnd;
        endcase
        we = write_enable_i && valid && m_mapped(addr_i) && !trap;

        n_cyc = m_cycle + 64'd1;
        if (we && addr_i == 12'hB00) n_cyc[31:0] = wd;
        if (we && addr_i == 12'hB80) n_cyc[63:32] = wd;

        n_mip = m_mip;
        if (we && addr_i == 12'h344) n_mip = n_mip & wd;
        if (trap) n_mip = n_mip & ~(32'd1 << k);
        n_mip = n_mip | {irq_i, 16'h0000};

        n_ms = m_mstatus;
        if (trap) n_ms = m_mstatus[3] ? 32'h80 : 32'h0;
        else if (mret_i) n_ms = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
        else if (we && addr_i == 12'h300) n_ms = wd & 32'h88;

        n_mie   = (we && addr_i == 12'h304) ? (wd & 32'hFFFF_0000) : m_mie;
        n_tv    = (we && addr_i == 12'h305) ? {wd[31:2], (wd[1:0] == 2'b01) ? 2'b01 : 2'b00} : m_mtvec;
        n_scr   = (we && addr_i == 12'h340) ? wd : m_mscratch;
        n_epc   = trap ? pc_i : ((we && addr_i == 12'h341) ? wd : m_mepc);
        n_cause = trap ? (32'h8000_0000 | 32'(k)) : ((we && addr_i == 12'h342) ? wd : m_mcause);

        m_mstatus = n_ms; m_mie = n_mie; m_mtvec = n_tv; m_mscratch = n_scr;
        m_mepc = n_epc; m_mcause = n_cause; m_mip = n_mip; m_cycle = n_cyc;
        m_trap_o = trap;
    endtask

    always @(posedge clk_i) begin
        if (!rst_i) m_reset();
        else m_step();
    end

    always @(negedge rst_i) m_reset();

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk_i) begin
        #3;
        check("read_data", read_data_o, m_read(addr_i));
        check("illegal", {31'd0, illegal_o},
              {31'd0, (opcode_i inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7}) && !m_mapped(addr_i)});
        check("trap_o", {31'd0, trap_o}, {31'd0, m_trap_o});
        check("mepc_o", mepc_o, m_mepc);
        check("trap_pc_o", trap_pc_o, m_trap_pc());
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d,
                         input logic we, input logic [15:0] irq, input logic mret);
        @(negedge clk_i);
        opcode_i       = op;
        addr_i         = a;
        rs1_data_i     = d;
        imm_data_i     = d;
        write_enable_i = we;
        irq_i          = irq;
        mret_i         = mret;
    endtask

    task automatic idle();
        drive(3'd0, 12'h000, 32'd0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        drive(3'd0, a, 32'd0, 1'b0, 16'h0, 1'b0);
        #4;
        check(name, read_data_o, exp);
    endtask

    task automatic wait_trap(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            idle();
            #4;
            if (trap_o) seen = 1'b1;
        end
        check(name, {31'd0, trap_o}, 32'd1);
    endtask

    logic [11:0] map_tab [9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h344, 12'hB00, 12'hB80};

    // ---------------- stimulus ----------------
    initial begin
        m_reset();
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset values, read while reset is still asserted.
        for (int i = 0; i < 9; i++) begin
            addr_i = map_tab[i];
            #1;
            check("reset_read", read_data_o, (map_tab[i] == 12'h305) ? TB_MTVEC : 32'd0);
        end
        opcode_i = 3'd1;
        addr_i   = 12'h123;
        #1;
        check("illegal_123", {31'd0, illegal_o}, 32'd1);
        opcode_i = 3'd0;

        // First increment on the first edge after release.
        @(negedge clk_i);
        rst_i  = 1'b1;
        addr_i = 12'hB00;
        #4;
        check("mcycle_rel0", read_data_o, 32'd0);
        @(negedge clk_i);
        #4;
        check("mcycle_rel1", read_data_o, 32'd1);

        // Vectored trap on irq line 1.
        pc_i = 32'h200;
        drive(3'd1, 12'h305, 32'h1001, 1'b1, 16'h0, 1'b0);
        drive(3'd1, 12'h304, 32'h0002_0000, 1'b1, 16'h0, 1'b0);
        drive(3'd1, 12'h300, 32'h8, 1'b1, 16'h0, 1'b0);
        drive(3'd0, 12'h000, 32'd0, 1'b0, 16'h0002, 1'b0);
        wait_trap("trap_irq1");
        check("mepc_irq1", mepc_o, 32'h200);
        check("trap_pc_irq1", trap_pc_o, 32'h1044);
        rd_check("mcause_irq1", 12'h342, 32'h8000_0011);
        rd_check("mstatus_irq1", 12'h300, 32'h80);
        rd_check("mip_irq1", 12'h344, 32'h0);

        // Priority: lines 0 and 3 together; then 3 after mret.
        drive(3'd1, 12'h304, 32'h0009_0000, 1'b1, 16'h0, 1'b0);
        drive(3'd1, 12'h300, 32'h8, 1'b1, 16'h0, 1'b0);
        drive(3'd0, 12'h000, 32'd0, 1'b0, 16'h0009, 1'b0);
        wait_trap("trap_prio0");
        rd_check("mcause_prio0", 12'h342, 32'h8000_0010);
        drive(3'd0, 12'h000, 32'd0, 1'b0, 16'h0, 1'b1);
        wait_trap("trap_prio3");
        rd_check("mcause_prio3", 12'h342, 32'h8000_0013);
        rd_check("mip_prio3", 12'h344, 32'h0);

        // Trap blocks a same-cycle CSR write and a same-cycle mret.
        drive(3'd1, 12'h340, 32'h11, 1'b1, 16'h0, 1'b0);
        drive(3'd0, 12'h000, 32'd0, 1'b0, 16'h0001, 1'b0);
        drive(3'd2, 12'h300, 32'h8, 1'b1, 16'h0, 1'b0);
        drive(3'd1, 12'h340, 32'h22, 1'b1, 16'h0, 1'b1);
        rd_check("mscratch_blocked", 12'h340, 32'h11);
        check("trap_blocked", {31'd0, trap_o}, 32'd1);
        rd_check("mstatus_after_mret_trap", 12'h300, 32'h80);

        // Counter carry and high-half write priority.
        drive(3'd1, 12'hB80, 32'd7, 1'b1, 16'h0, 1'b0);
        drive(3'd1, 12'hB00, 32'hFFFF_FFFF, 1'b1, 16'h0, 1'b0);
        rd_check("mcycle_max", 12'hB00, 32'hFFFF_FFFF);
        rd_check("mcycle_wrap", 12'hB00, 32'd0);
        rd_check("mcycleh_carry", 12'hB80, 32'd8);
        drive(3'd1, 12'hB00, 32'hFFFF_FFFF, 1'b1, 16'h0, 1'b0);
        drive(3'd1, 12'hB80, 32'd5, 1'b1, 16'h0, 1'b0);
        rd_check("mcycleh_write_wins", 12'hB80, 32'd5);
        rd_check("mcycle_after_hwrite", 12'hB00, 32'd1);

        // Asynchronous reset while trap_o is high.
        drive(3'd0, 12'h000, 32'd0, 1'b0, 16'h0001, 1'b0);
        drive(3'd2, 12'h300, 32'h8, 1'b1, 16'h0, 1'b0);
        idle();
        @(posedge clk_i);
        #2;
        check("trap_before_rst", {31'd0, trap_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check("trap_async_rst", {31'd0, trap_o}, 32'd0);
        check("mepc_async_rst", mepc_o, 32'd0);
        check("trap_pc_async_rst", trap_pc_o, TB_MTVEC & 32'hFFFF_FFFC);
        repeat (2) idle();
        @(negedge clk_i);
        rst_i = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [11:0] a;
            logic [31:0] d;
            logic [15:0] irq;
            a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : map_tab[$urandom_range(0, 8)];
            d = ($urandom_range(0, 3) == 0) ? 32'h8 : $urandom;
            irq = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
            drive(3'($urandom_range(0, 7)), a, d, 1'($urandom_range(0, 1)), irq,
                  ($urandom_range(0, 15) == 0));
            imm_data_i = $urandom;
            pc_i       = $urandom;
        end

        idle();
        @(negedge clk_i);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
